tm1638_refresher: RTL



---
 rtl/tm1638_refresher.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/tm1638_refresher.sv
// TM1638 refresher: walks every chip through the six-transaction refresh
// sequence and drives an external byte-oriented SPI controller.
module tm1638_refresher #(
  parameter int unsigned NUM_CHIPS       = 1,
  parameter int unsigned POWER_UP_CYCLES = 50_000_000,
  parameter int unsigned BUSY_TIMEOUT    = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [NUM_CHIPS*128-1:0] i_leds,
  input  logic [2:0]               i_brightness,
  input  logic                     i_display_on,
  input  logic                     i_spi_busy,
  output logic                     o_spi_activate,
  output logic [NUM_CHIPS-1:0]     o_spi_cs,
  output logic [39:0]              o_spi_out_data,
  output logic [2:0]               o_spi_out_count,
  output logic                     o_ready,
  output logic                     o_done,
  output logic                     o_error
);

  localparam int unsigned OUT_BYTES = 5;
  localparam int unsigned LED_BYTES = 16;
  localparam int unsigned ROW_W     = LED_BYTES * 8;
  localparam int unsigned DATA_W    = OUT_BYTES * 8;
  localparam int unsigned SNAP_W    = NUM_CHIPS * ROW_W;
  localparam int unsigned CHIP_W    = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;
  localparam int unsigned STEP_W    = 3;
  localparam int unsigned PU_W      = $clog2(POWER_UP_CYCLES + 1) + 1;
  localparam int unsigned TO_W      = $clog2(BUSY_TIMEOUT + 1) + 1;

  typedef enum logic [2:0] {
    S_POWER_UP,
    S_IDLE,
    S_BUILD,
    S_SEND,
    S_AWAIT,
    S_ERROR
  } state_t;

  state_t                r_state;
  logic [PU_W-1:0]       r_pu_cnt;
  logic [TO_W-1:0]       r_to_cnt;
  logic                  r_seen_busy;
  logic [CHIP_W-1:0]     r_chip;
  logic [STEP_W-1:0]     r_step;
  logic [SNAP_W-1:0]     r_snap;
  logic [2:0]            r_bright;
  logic                  r_disp;
  logic                  r_act;
  logic [NUM_CHIPS-1:0]  r_cs;
  logic [DATA_W-1:0]     r_data;
  logic [2:0]            r_count;
  logic                  r_ready;
  logic                  r_done;
  logic                  r_error;

  logic [ROW_W-1:0]      w_row;
  logic [1:0]            w_k;
  logic [DATA_W-1:0]     w_data;
  logic [2:0]            w_count;

  // Assemble the payload of the current (chip, step) transaction from the snapshot
  always_comb begin
    w_row   = '0;
    w_k     = 2'(r_step - 3'd1);
    w_data  = '0;
    w_count = '0;
    for (int c = 0; c < NUM_CHIPS; c++) begin
      if (r_chip == CHIP_W'(c)) w_row = r_snap[c*ROW_W +: ROW_W];
    end
    case (r_step)
      3'd0: begin
        w_data[7:0] = 8'h40;
        w_count     = 3'd1;
      end
      3'd1, 3'd2, 3'd3, 3'd4: begin
        w_data[7:0]  = 8'hC0 + {4'b0000, w_k, 2'b00};
        w_data[39:8] = w_row[{w_k, 5'b00000} +: 32];
        w_count      = 3'd5;
      end
      3'd5: begin
        w_data[7:0] = {4'b1000, r_disp, r_bright};
        w_count     = 3'd1;
      end
      default: begin
        w_data  = '0;
        w_count = '0;
      end
    endcase
  end

  // Sequencer: power-up wait, snapshot, per-transaction handshake and timeout
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_POWER_UP;
      r_pu_cnt    <= PU_W'(POWER_UP_CYCLES);
      r_to_cnt    <= '0;
      r_seen_busy <= 1'b0;
      r_chip      <= '0;
      r_step      <= '0;
      r_snap      <= '0;
      r_bright    <= '0;
      r_disp      <= 1'b0;
      r_act       <= 1'b0;
      r_cs        <= '0;
      r_data      <= '0;
      r_count     <= '0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_POWER_UP: begin
          if (r_pu_cnt <= PU_W'(1)) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_pu_cnt <= r_pu_cnt - PU_W'(1);
          end
        end
        S_IDLE: begin
          if (i_start) begin
            r_error  <= 1'b0;
            r_snap   <= i_leds;
            r_bright <= i_brightness;
            r_disp   <= i_display_on;
            r_chip   <= '0;
            r_step   <= '0;
            r_ready  <= 1'b0;
            r_state  <= S_BUILD;
          end
        end
        S_BUILD: begin
          r_data  <= w_data;
          r_count <= w_count;
          r_cs    <= NUM_CHIPS'(1) << r_chip;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (!i_spi_busy) begin
            r_act       <= 1'b1;
            r_to_cnt    <= '0;
            r_seen_busy <= 1'b0;
            r_state     <= S_AWAIT;
          end
        end
        S_AWAIT: begin
          if (i_spi_busy) begin
            r_act       <= 1'b0;
            r_seen_busy <= 1'b1;
          end else if (r_seen_busy) begin
            if (r_step == STEP_W'(5)) begin
              r_step <= '0;
              if (r_chip == CHIP_W'(NUM_CHIPS - 1)) begin
                r_done  <= 1'b1;
                r_ready <= 1'b1;
                r_cs    <= '0;
                r_state <= S_IDLE;
              end else begin
                r_chip  <= r_chip + CHIP_W'(1);
                r_state <= S_BUILD;
              end
            end else begin
              r_step  <= r_step + STEP_W'(1);
              r_state <= S_BUILD;
            end
          end else if (r_to_cnt >= TO_W'(BUSY_TIMEOUT - 1)) begin
            r_act   <= 1'b0;
            r_cs    <= '0;
            r_error <= 1'b1;
            r_state <= S_ERROR;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        S_ERROR: begin
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_POWER_UP;
        end
      endcase
    end
  end

  assign o_spi_activate  = r_act;
  assign o_spi_cs        = r_cs;
  assign o_spi_out_data  = r_data;
  assign o_spi_out_count = r_count;
  assign o_ready         = r_ready;
  assign o_done          = r_done;
  assign o_error         = r_error;

endmodule
